// File: rtl/burst_mem.sv
// -----------------------------------------------------------------------------
// burst_mem
//   Single-port synchronous memory with burst access. A command on the req
//   channel carries the start address, the direction and the beat count minus
//   one. Write beats arrive on the wdata/wvalid/wready channel. Read beats leave
//   through a registered rdata/rvalid pair that honours rready backpressure.
//   After reset the whole array can optionally be zeroed one word per cycle.
//   Burst addresses wrap modulo DEPTH. done pulses for one cycle after the
//   final beat of every completed burst.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  command handshake
//   req_write            1 = write burst, 0 = read burst
//   req_addr, req_len    start address, beats minus one
//   wdata/wvalid/wready  write beat channel
//   rdata/rvalid/rready  read beat channel (rdata, rvalid registered)
//   done                 one-cycle completion pulse
//   dbg_state            current FSM state (0 CLEAR, 1 IDLE, 2 WRITE, 3 READ)
//
// Handshake rule for every channel: a transfer happens at a rising clk edge
// where valid and ready are both 1. A producer holding valid=1 keeps its
// payload stable until that edge. ready may depend on state but never on the
// valid it is paired with.
// -----------------------------------------------------------------------------
module burst_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = 3,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  // Counts accepted write beats or issued read beats; one bit wider than
  // r_len so a full 2**LEN_WIDTH burst never wraps it.
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_done;

  logic [CW-1:0]         w_beats;
  logic                  w_req_ready;
  logic                  w_wready;
  logic                  w_wr_beat;
  logic                  w_rd_issue;
  logic                  w_last_wr;
  logic                  w_last_rd;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_beats   = CW'(r_len) + CW'(1);
  // r_cnt holds the beats already accepted, so the current beat is the last
  // one when r_cnt equals len.
  assign w_last_wr = (r_cnt == CW'(r_len));
  // All beats issued and the final one is handshaking now.
  assign w_last_rd = r_rvalid && rready && (r_cnt == w_beats);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLEAR: if (&r_addr) w_next_state = ST_IDLE;
      ST_IDLE:  if (req_valid) w_next_state = req_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (wvalid && w_last_wr) w_next_state = ST_IDLE;
      ST_READ:  if (w_last_rd) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output / strobe logic. Everything is gated by rst so the handshakes are
  // closed while reset is held, whatever the state register still says.
  always_comb begin
    w_req_ready = 1'b0;
    w_wready    = 1'b0;
    w_rd_issue  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = wdata;
    if (!rst) begin
      case (r_state)
        ST_CLEAR: begin
          w_mem_we    = 1'b1;
          w_mem_wdata = '0;
        end
        ST_IDLE:  w_req_ready = 1'b1;
        ST_WRITE: begin
          w_wready = 1'b1;
          w_mem_we = wvalid;
        end
        ST_READ:  w_rd_issue = (!r_rvalid || rready) && (r_cnt < w_beats);
        default:  ;
      endcase
    end
  end

  assign w_wr_beat = w_wready && wvalid;

  // Array: no reset, so contents survive reset unless the CLEAR pass runs.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_mem_wdata;
    end
  end

  // Address, beat counter and read output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_CLEAR: r_addr <= r_addr + 1'b1;  // wraps back to 0 on exit
        ST_IDLE: begin
          if (w_req_ready && req_valid) begin
            r_addr <= req_addr;
            r_len  <= req_len;
            r_cnt  <= '0;
          end
        end
        ST_WRITE: begin
          if (w_wr_beat) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last_wr) r_done <= 1'b1;
          end
        end
        ST_READ: begin
          if (w_rd_issue) begin
            r_rdata  <= r_mem[r_addr];
            r_rvalid <= 1'b1;
            r_addr   <= r_addr + 1'b1;
            r_cnt    <= r_cnt + 1'b1;
          end else if (rready) begin
            r_rvalid <= 1'b0;
          end
          if (w_last_rd) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign wready    = w_wready;
  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_burst_mem.sv
// -----------------------------------------------------------------------------
// tb_burst_mem
//   Two burst_mem instances share every input: u_clr (INIT_CLEAR=1) and
//   u_keep (INIT_CLEAR=0). After each reset the drivers wait for u_clr to
//   finish clearing while u_keep sits idle with no command. From then on both
//   see identical traffic in lock-step. The reference model is a plain word
//   array per instance. Read expectations are queued when a read command is
//   issued, and a negedge monitor pops and compares every read handshake.
// -----------------------------------------------------------------------------
module tb_burst_mem;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int LW    = 3;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          rready;

  logic          a_req_ready, a_wready, a_rvalid, a_done;
  logic [DW-1:0] a_rdata;
  logic [1:0]    a_dbg;
  logic          b_req_ready, b_wready, b_rvalid, b_done;
  logic [DW-1:0] b_rdata;
  logic [1:0]    b_dbg;

  burst_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .INIT_CLEAR(1'b1)) u_clr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wvalid(wvalid), .wready(a_wready),
    .rdata(a_rdata), .rvalid(a_rvalid), .rready(rready),
    .done(a_done), .dbg_state(a_dbg)
  );

  burst_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .INIT_CLEAR(1'b0)) u_keep (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wvalid(wvalid), .wready(b_wready),
    .rdata(b_rdata), .rvalid(b_rvalid), .rready(rready),
    .done(b_done), .dbg_state(b_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  bit            known_b [DEPTH];   // u_keep words with defined contents
  logic [DW-1:0] exp_q_a [$];
  logic [DW:0]   exp_q_b [$];       // bit DW set = value must be checked
  logic [DW-1:0] wbuf [8];
  bit            exp_done = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_a = 1'b0, hold_b = 1'b0;
  logic [DW-1:0] held_a = '0, held_b = '0;
  logic [DW-1:0] e_a;
  logic [DW:0]   e_b;

  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      // A beat stalled by rready=0 must stay put.
      if (hold_a) begin
        chk("a_hold_rvalid", int'(a_rvalid), 1);
        chk("a_hold_rdata", int'(a_rdata), int'(held_a));
      end
      if (hold_b) begin
        chk("b_hold_rvalid", int'(b_rvalid), 1);
        chk("b_hold_rdata", int'(b_rdata), int'(held_b));
      end
      if (a_rvalid && rready) begin
        if (exp_q_a.size() == 0) chk("a_unexpected_beat", 1, 0);
        else begin
          e_a = exp_q_a.pop_front();
          chk("a_rdata", int'(a_rdata), int'(e_a));
        end
      end
      if (b_rvalid && rready) begin
        if (exp_q_b.size() == 0) chk("b_unexpected_beat", 1, 0);
        else begin
          e_b = exp_q_b.pop_front();
          if (e_b[DW]) chk("b_rdata", int'(b_rdata), int'(e_b[DW-1:0]));
        end
      end
      hold_a = a_rvalid && !rready;
      held_a = a_rdata;
      hold_b = b_rvalid && !rready;
      held_b = b_rdata;
    end
    if (exp_done || a_done || b_done) begin
      chk("a_done", int'(a_done), int'(exp_done));
      chk("b_done", int'(b_done), int'(exp_done));
    end
    exp_done = 1'b0;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input bit w, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, output int waited);
    bit hs = 1'b0;
    int n  = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_len   = len;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = a_req_ready;
      if (hs) chk("b_req_ready_lockstep", int'(b_req_ready), 1);
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_len   = LW'($urandom);
    if (!hs) chk("cmd_accept_timeout", 0, 1);
    waited = n;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input bit rnd, input logic [15:0] pat, input int abort_after);
    int            waited;
    int            k = 0;
    int            beats = 0;
    bit            hs;
    logic [AW-1:0] a;
    send_cmd(1'b1, addr, len, waited);
    while (beats < int'(len) + 1 && !(abort_after >= 0 && beats == abort_after) && k < 300) begin
      wvalid = rnd ? 1'($urandom_range(0, 1)) : (k < 16 ? pat[k] : 1'b1);
      wdata  = wvalid ? wbuf[beats] : DW'($urandom);
      @(negedge clk);
      hs = wvalid && a_wready;
      @(posedge clk); #1;
      k++;
      if (hs) begin
        a          = addr + AW'(beats);
        mem_a[a]   = wbuf[beats];
        mem_b[a]   = wbuf[beats];
        known_b[a] = 1'b1;
        beats++;
      end
    end
    wvalid = 1'b0;
    if (beats == int'(len) + 1) exp_done = 1'b1;
    else if (abort_after < 0) chk("write_timeout", beats, int'(len) + 1);
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input bit rnd, input logic [15:0] pat, input bit chk_tput,
                            output int waited);
    int            n = 1;
    int            k = 0;
    int            got = 0;
    int            first = 0;
    int            last = 0;
    bit            hs;
    logic [AW-1:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + AW'(i);
      exp_q_a.push_back(mem_a[a]);
      exp_q_b.push_back({known_b[a], mem_b[a]});
    end
    send_cmd(1'b0, addr, len, waited);
    while (got < int'(len) + 1 && n < 300) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : (k < 16 ? pat[k] : 1'b1);
      @(negedge clk);
      hs = a_rvalid && rready;
      if (a_rvalid && first == 0) first = n;
      @(posedge clk); #1;
      if (hs) begin
        got++;
        if (got == int'(len) + 1) last = n;
      end
      if (first != 0) k++;
      n++;
    end
    rready = 1'($urandom_range(0, 1));
    if (got == int'(len) + 1) exp_done = 1'b1;
    else chk("read_timeout", got, int'(len) + 1);
    chk("rd_first_rvalid_cycle", first, 2);
    if (chk_tput) chk("rd_last_beat_cycle", last, int'(len) + 2);
    chk("a_queue_drained", exp_q_a.size(), 0);
  endtask

  task automatic do_reset();
    int n = 1;
    for (int i = 0; i < DEPTH; i++) mem_a[i] = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_a_req_ready", int'(a_req_ready), 0);
    chk("rst_a_wready", int'(a_wready), 0);
    chk("rst_a_rvalid", int'(a_rvalid), 0);
    chk("rst_a_rdata", int'(a_rdata), 0);
    chk("rst_a_done", int'(a_done), 0);
    chk("rst_b_req_ready", int'(b_req_ready), 0);
    chk("rst_b_rvalid", int'(b_rvalid), 0);
    chk("rst_b_rdata", int'(b_rdata), 0);
    chk("rst_a_state_clear", int'(a_dbg), 0);
    chk("rst_b_state_idle", int'(b_dbg), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      if (n == 1) chk("b_ready_after_rst", int'(b_req_ready), 1);
      if (a_req_ready) break;
      @(posedge clk); #1;
      n++;
    end
    chk("a_first_ready_cycle", n, 33);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int w;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; known_b[i] = 1'b0;
    end
    do_reset();

    // cleared array reads back as zeros
    read_burst(5'd0, 3'd7, 1'b0, 16'hFFFF, 1'b1, w);

    // give every word a known value in both instances
    for (int blk = 0; blk < 4; blk++) begin
      for (int j = 0; j < 8; j++) wbuf[j] = DW'($urandom);
      write_burst(AW'(blk * 8), 3'd7, 1'b1, 16'h0, -1);
    end

    // gapped write 1,0,1,1,0,1 then a read in the done cycle
    wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
    write_burst(5'd4, 3'd3, 1'b0, 16'hFFED, -1);
    read_burst(5'd4, 3'd0, 1'b0, 16'hFFFF, 1'b1, w);
    chk("done_cycle_accept_wait", w, 1);
    read_burst(5'd4, 3'd3, 1'b0, 16'hFFFF, 1'b1, w);

    // address wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(5'd30, 3'd3, 1'b0, 16'hFFFF, -1);
    read_burst(5'd0, 3'd1, 1'b0, 16'hFFFF, 1'b1, w);
    read_burst(5'd30, 3'd1, 1'b0, 16'hFFFF, 1'b1, w);

    // backpressure 1,0,0,1,1,0,1
    read_burst(5'd4, 3'd3, 1'b0, 16'hFFD9, 1'b0, w);

    // randomised traffic
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 8; j++) wbuf[j] = DW'($urandom);
        write_burst(AW'($urandom), LW'($urandom), 1'b1, 16'h0, -1);
      end else begin
        read_burst(AW'($urandom), LW'($urandom), 1'b1, 16'h0, 1'b0, w);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // reset after 3 of 8 write beats: no done, partial data kept in u_keep
    for (int j = 0; j < 8; j++) wbuf[j] = DW'($urandom);
    write_burst(5'd8, 3'd7, 1'b0, 16'hFFFF, 3);
    do_reset();
    read_burst(5'd8, 3'd7, 1'b0, 16'hFFFF, 1'b1, w);

    repeat (10) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 8; j++) wbuf[j] = DW'($urandom);
        write_burst(AW'($urandom), LW'($urandom), 1'b1, 16'h0, -1);
      end else begin
        read_burst(AW'($urandom), LW'($urandom), 1'b1, 16'h0, 1'b0, w);
      end
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/burst_mem.md
Name: burst_mem

Overview:
Parametrised single-port synchronous memory with a request/ready command channel and burst transfers. A command gives a start address and a beat count. Write beats arrive on a valid/ready data channel; read beats leave on a registered valid/ready channel with backpressure. It succeeds the fixed 32x8 read/write memory, is generalised in width and depth, and adds reset-time clearing, address wrap and a completion pulse.

Parameters:
DATA_WIDTH, 8, bits per word.
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH words (derived, not overridable).
LEN_WIDTH, 3, width of req_len; burst length = req_len+1, range 1..2**LEN_WIDTH beats.
INIT_CLEAR, 1, 1 = zero the entire array after every reset; 0 = array contents untouched by reset.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  command valid.
req_ready  output  1  command accepted when req_valid && req_ready at a clock edge.
req_write  input  1  1 = write burst, 0 = read burst; sampled at acceptance.
req_addr  input  ADDR_WIDTH  start address; sampled at acceptance.
req_len  input  LEN_WIDTH  beats minus one; sampled at acceptance.
wdata  input  DATA_WIDTH  write beat data.
wvalid  input  1  write beat valid.
wready  output  1  write beat accepted when wvalid && wready at a clock edge.
rdata  output  DATA_WIDTH  read beat data (registered).
rvalid  output  1  read beat valid (registered).
rready  input  1  read beat consumed when rvalid && rready at a clock edge.
done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: rst is sampled at posedge clk. While rst=1 and on the edge after it: req_ready=0, wready=0, rvalid=0, rdata=0, done=0, internal address/count=0.
- After reset the state is CLEAR if INIT_CLEAR=1, otherwise IDLE.
- Reset mid-burst aborts the burst. No done pulse. Words already written are kept unless INIT_CLEAR=1 clears them.
- FSM states: CLEAR, IDLE, WRITE, READ.
- CLEAR:
  - Writes 0 to address 0, 1, ..., DEPTH-1, one word per cycle, for exactly DEPTH cycles, then goes to IDLE.
  - req_ready=0 throughout. With DEPTH=32, req_ready first rises in the 33rd cycle after rst deasserts.
- IDLE:
  - req_ready=1, wready=0, rvalid=0.
  - On an accepted command, latch addr into cur_addr, latch len into remaining, and go to WRITE or READ.
  - wvalid and rready are ignored in IDLE.
- WRITE:
  - req_ready=0, wready=1.
  - Each accepted beat: mem[cur_addr] <= wdata; cur_addr <= cur_addr+1 (modulo DEPTH).
  - Idle cycles (wvalid=0) are allowed and change nothing.
  - On the (len+1)th accepted beat: go to IDLE and assert done for the following cycle.
- READ:
  - req_ready=0, wready=0. Words are read from the array into the rdata register.
  - If (!rvalid || rready) and beats issued < len+1: rdata <= mem[cur_addr], rvalid <= 1, cur_addr++ (modulo DEPTH), issued++.
  - Else if rready: rvalid <= 0.
  - rdata and rvalid stay stable while rvalid=1 and rready=0.
  - First rvalid is in the 2nd cycle after the acceptance edge.
  - With rready held at 1, one beat is delivered per cycle.
  - On handshake of the final beat: rvalid <= 0, go to IDLE, assert done for the following cycle.
- Completion cycle: done=1 and req_ready=1 in the same cycle. A new command may be accepted in that cycle, so back-to-back bursts have one idle-free turnaround cycle.
- Address wrap: a burst crossing DEPTH-1 continues at 0. Example: addr=30, len=3 touches 30, 31, 0, 1.
- Read-after-write: a read command issued after a write's done returns the new data. No bypass is needed because the FSM serialises operations.
- req_len=0 gives a single-beat burst.
- Maximum burst: req_len=2**LEN_WIDTH-1 beats are all transferred. The counter must not overflow; the beat counter is LEN_WIDTH+1 bits.
- Arithmetic: cur_addr increments are ADDR_WIDTH bits with natural wrap. Data is stored and returned unmodified, full DATA_WIDTH.

Test Plan:
- Reset, INIT_CLEAR=1, DEPTH=32 -> req_ready=0 for 32 cycles after rst falls. Then a read of addr 0, len 7 returns eight 0x00 beats and one done pulse.
- Write addr 4, len 3, data 0xA1,0xA2,0xA3,0xA4 with wvalid gaps (1,0,1,1,0,1) -> done once after the 4th beat. A read of addr 4, len 3 returns A1..A4 in order, with the first rvalid 2 cycles after acceptance.
- Write addr 30, len 3, data 0x11,0x22,0x33,0x44 -> read addr 0, len 1 returns 0x33, 0x44; read addr 30, len 1 returns 0x11, 0x22 (wrap).
- Read burst len 3 with rready toggling 1,0,0,1,1,0,1 -> rdata held stable while rready=0. Exactly 4 handshakes in address order; done the cycle after the last one.
- Write addr 8, len 7 interrupted by rst after 3 beats, INIT_CLEAR=0 -> no done pulse. After reset, read addr 8, len 7 returns the 3 written values followed by the prior contents.
- done cycle with req_valid=1 (read addr 4, len 0) -> accepted immediately; returns 0xA1 with no extra idle cycle.
